// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for a raster pixel stream, two line buffers deep.
// Define SOF_RESYNC_EN to add the sof input, which forces an accepted pixel to be (0,0).
module sobel_window_gen #(
    parameter int unsigned M  = 600,
    parameter int unsigned N  = 450,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            data_valid,
`ifdef SOF_RESYNC_EN
    input  logic            sof,
`endif
    input  logic [DW-1:0]   Din,
    output logic            win_valid,
    output logic [9*DW-1:0] window,
    output logic            in_frame,
    output logic            frame_done
);

    localparam int unsigned CW = $clog2(M);
    localparam int unsigned RW = $clog2(N);

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_lb0 [M];
    logic [DW-1:0]   r_lb1 [M];
    logic [3*DW-1:0] r_cl;
    logic [3*DW-1:0] r_cm;
    logic            r_win_valid;
    logic [9*DW-1:0] r_window;
    logic            r_in_frame;
    logic            r_frame_done;

    logic            w_sof;
    logic [CW-1:0]   w_col;
    logic [RW-1:0]   w_row;
    logic [CW-1:0]   w_col_nxt;
    logic [RW-1:0]   w_row_nxt;
    logic            w_last_col;
    logic            w_last_row;
    logic            w_win;
    logic [DW-1:0]   w_lb0_rd;
    logic [DW-1:0]   w_lb1_rd;
    logic [3*DW-1:0] w_new_col;
    logic [9*DW-1:0] w_window_nxt;

    // Effective position of the pixel on Din; a resync pixel is always (0,0).
    always_comb begin
`ifdef SOF_RESYNC_EN
        w_sof = data_valid & sof;
`else
        w_sof = 1'b0;
`endif
        w_col      = w_sof ? '0 : r_col;
        w_row      = w_sof ? '0 : r_row;
        w_last_col = (w_col == CW'(M - 1));
        w_last_row = (w_row == RW'(N - 1));
        w_win      = (w_row >= RW'(2)) && (w_col >= CW'(2));
        w_col_nxt  = w_last_col ? '0 : w_col + CW'(1);
        if (w_last_col) begin
            w_row_nxt = w_last_row ? '0 : w_row + RW'(1);
        end else begin
            w_row_nxt = w_row;
        end
    end

    assign w_lb0_rd  = r_lb0[w_col];
    assign w_lb1_rd  = r_lb1[w_col];
    // Column layout: top (row r-2) in the high slice, bottom (row r) in the low slice.
    assign w_new_col = {w_lb0_rd, w_lb1_rd, Din};

    // Row-major packing, w0 (top-left) in the least significant slice.
    assign w_window_nxt = {w_new_col[DW-1:0],      r_cm[DW-1:0],      r_cl[DW-1:0],
                           w_new_col[2*DW-1:DW],   r_cm[2*DW-1:DW],   r_cl[2*DW-1:DW],
                           w_new_col[3*DW-1:2*DW], r_cm[3*DW-1:2*DW], r_cl[3*DW-1:2*DW]};

    // Line buffers are read-before-write at the same column; contents need no reset.
    always_ff @(posedge clk) begin
        if (data_valid && !rst) begin
            r_lb0[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= Din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_cl         <= '0;
            r_cm         <= '0;
            r_win_valid  <= 1'b0;
            r_window     <= '0;
            r_in_frame   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= data_valid & w_win;
            r_frame_done <= data_valid & w_last_col & w_last_row;
            if (data_valid) begin
                r_col      <= w_col_nxt;
                r_row      <= w_row_nxt;
                r_cl       <= r_cm;
                r_cm       <= w_new_col;
                r_window   <= w_window_nxt;
                r_in_frame <= !(w_last_col && w_last_row);
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign window     = r_window;
    assign in_frame   = r_in_frame;
    assign frame_done = r_frame_done;

endmodule
